// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared bank geometry, request record and we-decode helper.
package mem_bank_pkg;
  localparam int NUM_BANKS = 4;
  localparam int REQ_WIDTH = 36;
  localparam int REQ_ADDR_W = 10;
  localparam int unsigned BANK_DEPTH [NUM_BANKS] = '{1024, 32, 1024, 750};
  typedef struct packed {
    logic                  write;
    logic [1:0]            bank;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_WIDTH-1:0]  wdata;
  } mem_req_t;
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] bank);
    return NUM_BANKS'(1) << bank;
  endfunction
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous request FIFO; pointers carry one wrap bit to tell full from empty.
module mem_req_fifo
  import mem_bank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  mem_req_t din,
  output mem_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  mem_req_t    mem_q [DEPTH];
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = wr_ptr_q == rd_ptr_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push && !full);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop && !empty);
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mem_bank_master.sv
// mem_bank_master: queued single-word initiator for the four-bank memory port, in-order read responses.
// MEM_BANK_MASTER_BOUNDS_EN drops out-of-range requests at enqueue and raises sticky err.
module mem_bank_master
  import mem_bank_pkg::*;
#(
  parameter int WIDTH  = REQ_WIDTH,
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_bank,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [WIDTH-1:0]       req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_bank,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   err,
  output logic [NUM_BANKS-1:0]   mem_we,
  output logic [WIDTH*4-1:0]     mem_a,
  output logic [WIDTH*4-1:0]     mem_wd,
  input  logic [WIDTH*4-1:0]     mem_rd
);
  mem_req_t         push_req, head;
  logic             full, empty, push, issue, issue_rd, oob;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_bank_q, rsp_bank_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  assign req_ready = !full;
  assign push      = req_valid && req_ready && !oob;
`ifdef MEM_BANK_MASTER_BOUNDS_EN
  logic err_q, err_d;
  assign oob   = 32'(req_addr) >= BANK_DEPTH[req_bank];
  assign err_d = err_q || (req_valid && req_ready && oob);
  assign err   = err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign oob = 1'b0;
  assign err = 1'b0;
`endif
  always_comb push_req = '{write: req_write, bank: req_bank, addr: REQ_ADDR_W'(req_addr), wdata: REQ_WIDTH'(req_wdata)};
  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .din   (push_req),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // Writes wait behind an unaccepted read response too, so memory order matches request order.
  assign issue    = !empty && (!rsp_valid_q || rsp_ready);
  assign issue_rd = issue && !head.write;
  always_comb begin
    mem_we = '0;
    mem_a  = '0;
    mem_wd = '0;
    if (issue) begin
      mem_a[int'(head.bank)*WIDTH +: WIDTH] = WIDTH'(head.addr);
      if (head.write) begin
        mem_we = bank_onehot(head.bank);
        mem_wd[int'(head.bank)*WIDTH +: WIDTH] = WIDTH'(head.wdata);
      end
    end
  end
  always_comb begin
    rsp_valid_d = issue_rd || (rsp_valid_q && !rsp_ready);
    rsp_bank_d  = issue_rd ? head.bank : rsp_bank_q;
    rsp_rdata_d = issue_rd ? mem_rd[int'(head.bank)*WIDTH +: WIDTH] : rsp_rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_bank_q  <= rsp_bank_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_bank  = rsp_bank_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule
